tdc_spi_slave: RTL
==================

Name: tdc_spi_slave

Overview:
SPI responder emulating the TDC chip's register interface, SPI mode 0 (CPOL=0, CPHA=0), MSB first. It lets the FPGA TDC controller be exercised in loopback on the board without the real TDC fitted. A frame is an 8-bit command followed by one 24-bit data word (bursts optional). Holds five writable 24-bit configuration registers and two read-only measurement registers.
- Samples csb/sclk/mosi in the clk domain; clk must be at least 4x sclk.

Parameters:
- ADDR_W, 6, address field width inside the command byte.
- DATA_W, 24, register and data-word width.
- SYNC_STAGES, 2, synchronizer depth on csb/sclk/mosi (minimum 2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- csb  input  1  SPI chip select, active low.
- sclk  input  1  SPI clock from the master.
- mosi  input  1  serial data from the master (master dout).
- miso  output  1  serial data to the master (master din).
- meas_time1  input  24  read-only register, address 0x10.
- meas_clkcnt  input  24  read-only register, address 0x11.
- reg_config  output  24  register at address 0x00.
- reg_coarseovf  output  24  register at address 0x01.
- reg_clkctrovf  output  24  register at address 0x02.
- reg_clkstopmask  output  24  register at address 0x03.
- reg_interrupts  output  24  register at address 0x04.
- wr_strobe  output  1  one-clk pulse on each register commit.
- wr_addr  output  6  address of the last commit.
- frame_err  output  1  one-clk pulse on an aborted or malformed frame.

Behaviour:
- Reset values: all reg_* = 24'h0; miso = 0; wr_strobe = 0; wr_addr = 0; frame_err = 0; FSM in IDLE.
- Inputs pass through SYNC_STAGES flops. Rising and falling sclk edges are detected on synchronized samples, and all actions occur on those detected edges.
- Command byte: bit7 reserved, bit6 = 1 for write / 0 for read, bits5:0 = address.
- FSM states:
  - IDLE -> CMD on synchronized csb low; bit counter cleared.
  - CMD: shift mosi on each rising sclk edge. After the 8th bit, latch the command and go to DATA.
  - DATA, read: on the 8th rising edge, load the shift register with the addressed value (0 for unmapped addresses). miso presents bit23 at the next falling edge, then shifts on each following falling edge.
  - DATA, write: shift mosi on each rising edge. On the 24th rising edge, commit the word to the addressed writable register; wr_strobe and wr_addr update in the same clk. Then go to DONE.
  - DONE: ignore further sclk edges until csb is high, then go to IDLE.
- Commit latency: the register is updated 1 clk after the synchronized 24th rising edge, i.e. SYNC_STAGES+1 clk after the pin edge.
- Writes to read-only or unmapped addresses: no register changes; wr_strobe stays low; frame_err pulses.
- csb going high before the 24th data bit, in any state other than IDLE or DONE: abort to IDLE, no commit, frame_err pulses.
- csb high in any state: FSM returns to IDLE; miso = 0 while csb is high.
- meas_* inputs are sampled at the load instant only; changes during shift-out are ignored.
- Reset mid-frame: everything returns to reset values immediately (asynchronous); partial data is discarded.
- sclk edges while csb is high are ignored.

Optional Feature:
- Macro: TDC_SPI_SLAVE_AUTOINC_EN.
- Defined: when a word completes with csb still low, stay in DATA. The address increments (wrapping at 2^ADDR_W) and the next 24 bits form the next word: a write commits per word, a read reloads per word. Each committed word pulses wr_strobe once.
- Undefined: after one word the FSM goes to DONE, and extra clocks are ignored (miso = 0).

Decomposition:
- Package tdc_spi_pkg holds:
  - register address constants: ADDR_CONFIG=0x00, ADDR_COARSEOVF=0x01, ADDR_CLKCTROVF=0x02, ADDR_CLKSTOPMASK=0x03, ADDR_INTERRUPTS=0x04, ADDR_TIME1=0x10, ADDR_CLKCNT=0x11;
  - command bit position CMD_WR_BIT=6;
  - FSM state encoding IDLE/CMD/DATA/DONE.
- One sub-module, tdc_spi_sync_edge: synchronizer chain plus rise/fall edge detect, instantiated for sclk and reused for csb/mosi (level output only).

Test Plan:
- Write 0x41 then 24'hA5C33C -> reg_coarseovf = 24'hA5C33C; wr_strobe pulses once; wr_addr = 1; all other registers stay 0.
- meas_time1 = 24'h123456, read 0x10 -> master captures 24'h123456 on its 24 rising edges; miso = 0 after csb rises.
- Write 0x45 (unmapped) then 24'hFFFFFF -> no register changes; frame_err pulses; wr_strobe stays low.
- Write 0x40, 12 data bits, then csb high -> reg_config unchanged; frame_err pulses; the next full frame writing 24'h00000F succeeds.
- Assert rst_n low in the middle of a write frame -> all outputs at reset values; a frame sent after release completes correctly.
- With TDC_SPI_SLAVE_AUTOINC_EN, burst write 0x40 plus words 1, 2, 3 -> reg_config=1, reg_coarseovf=2, reg_clkctrovf=3; three wr_strobe pulses.

Source files
------------

// File: rtl/tdc_spi_pkg.sv
// tdc_spi_pkg: shared constants and types for the TDC register-interface emulator.
//   - Register map addresses (writable 0x00..0x04, read-only 0x10/0x11)
//   - Command byte layout (bit7 reserved, bit6 write flag, low bits address)
//   - Frame FSM state encoding
package tdc_spi_pkg;

    localparam int ADDR_CONFIG      = 'h00;
    localparam int ADDR_COARSEOVF   = 'h01;
    localparam int ADDR_CLKCTROVF   = 'h02;
    localparam int ADDR_CLKSTOPMASK = 'h03;
    localparam int ADDR_INTERRUPTS  = 'h04;
    localparam int ADDR_TIME1       = 'h10;
    localparam int ADDR_CLKCNT      = 'h11;

    localparam int CMD_WR_BIT = 6;
    localparam int NUM_WREGS  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    // Writable registers occupy the contiguous range 0..NUM_WREGS-1.
    function automatic logic is_writable(input int a);
        return (a >= 0) && (a < NUM_WREGS);
    endfunction

endpackage

// File: rtl/tdc_spi_sync_edge.sv
// tdc_spi_sync_edge: multi-flop synchronizer with rise/fall detection.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   din        : asynchronous input pin
//   level      : synchronized level (SYNC_STAGES clk latency)
//   rise, fall : one-clk pulses on a synchronized level change
// RST_VAL sets the chain's reset level (idle level of the pin).
module tdc_spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {SYNC_STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign level = chain[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/tdc_spi_slave.sv
// tdc_spi_slave: SPI mode-0 responder emulating the TDC register interface.
// Frame = 8-bit command (bit6 write, low bits address) + 24-bit data word.
// Ports:
//   clk, rst_n            : system clock (>= 4x sclk), async active-low reset
//   csb, sclk, mosi, miso : SPI pins (miso driven from clk domain)
//   meas_time1/clkcnt     : read-only values at 0x10/0x11, sampled at load
//   reg_*                 : writable registers 0x00..0x04
//   wr_strobe, wr_addr    : commit pulse and address of last commit
//   frame_err             : pulse on aborted frame or write to non-writable address
// Optional: define TDC_SPI_SLAVE_AUTOINC_EN for burst access with address
// auto-increment; otherwise one word per frame and extra clocks are ignored.
module tdc_spi_slave
    import tdc_spi_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              csb,
    input  logic              sclk,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] meas_time1,
    input  logic [DATA_W-1:0] meas_clkcnt,
    output logic [DATA_W-1:0] reg_config,
    output logic [DATA_W-1:0] reg_coarseovf,
    output logic [DATA_W-1:0] reg_clkctrovf,
    output logic [DATA_W-1:0] reg_clkstopmask,
    output logic [DATA_W-1:0] reg_interrupts,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam int IDX_W = $clog2(NUM_WREGS);

    logic csb_s, sclk_s, sclk_rise, sclk_fall, mosi_s;
    logic unused_csb_rise, unused_csb_fall, unused_mosi_rise, unused_mosi_fall;
    logic unused_sclk_level;

    tdc_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csb (
        .clk(clk), .rst_n(rst_n), .din(csb),
        .level(csb_s), .rise(unused_csb_rise), .fall(unused_csb_fall));

    tdc_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .din(sclk),
        .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall));

    tdc_spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .din(mosi),
        .level(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall));

    assign unused_sclk_level = sclk_s;

    state_t                          state;
    logic [CNT_W-1:0]                bit_cnt;
    // Reserved command bit simply falls off the end of this short shifter.
    logic [CMD_WR_BIT-1:0]           cmd_sh;
    logic [CMD_WR_BIT:0]             cmd_word;
    logic                            is_wr;
    logic [ADDR_W-1:0]               addr;
    logic [DATA_W-2:0]               rx_sh;
    logic [DATA_W-1:0]               rx_word;
    logic [DATA_W-1:0]               tx_sh;
    logic [NUM_WREGS-1:0][DATA_W-1:0] wregs;
    // Set once a full word has completed; lets a burst end cleanly on a word boundary.
    logic                            any_word;

    assign cmd_word = {cmd_sh, mosi_s};
    assign rx_word  = {rx_sh, mosi_s};

    function automatic logic [DATA_W-1:0] rd_val(input logic [ADDR_W-1:0] a);
        int ai;
        ai = int'(a);
        if (is_writable(ai))        return wregs[a[IDX_W-1:0]];
        else if (ai == ADDR_TIME1)  return meas_time1;
        else if (ai == ADDR_CLKCNT) return meas_clkcnt;
        else                        return '0;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            cmd_sh    <= '0;
            is_wr     <= 1'b0;
            addr      <= '0;
            rx_sh     <= '0;
            tx_sh     <= '0;
            wregs     <= '0;
            any_word  <= 1'b0;
            miso      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            frame_err <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            if (csb_s) begin
                if (state == CMD || (state == DATA && !(any_word && bit_cnt == '0)))
                    frame_err <= 1'b1;
                state <= IDLE;
                miso  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state    <= CMD;
                        bit_cnt  <= '0;
                        any_word <= 1'b0;
                        miso     <= 1'b0;
                    end
                    CMD: if (sclk_rise) begin
                        cmd_sh <= cmd_word[CMD_WR_BIT-1:0];
                        if (bit_cnt == CNT_W'(7)) begin
                            bit_cnt <= '0;
                            is_wr   <= cmd_word[CMD_WR_BIT];
                            addr    <= cmd_word[ADDR_W-1:0];
                            tx_sh   <= rd_val(cmd_word[ADDR_W-1:0]);
                            state   <= DATA;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                    DATA: begin
                        if (sclk_fall && !is_wr) begin
                            miso  <= tx_sh[DATA_W-1];
                            tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
                        end
                        if (sclk_rise) begin
                            rx_sh <= rx_word[DATA_W-2:0];
                            if (bit_cnt == CNT_W'(DATA_W-1)) begin
                                bit_cnt  <= '0;
                                any_word <= 1'b1;
                                if (is_wr) begin
                                    if (is_writable(int'(addr))) begin
                                        wregs[addr[IDX_W-1:0]] <= rx_word;
                                        wr_strobe <= 1'b1;
                                        wr_addr   <= addr;
                                    end else begin
                                        frame_err <= 1'b1;
                                    end
                                end
`ifdef TDC_SPI_SLAVE_AUTOINC_EN
                                addr  <= addr + ADDR_W'(1);
                                tx_sh <= rd_val(addr + ADDR_W'(1));
`else
                                state <= DONE;
                                miso  <= 1'b0;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    DONE: miso <= 1'b0;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign reg_config      = wregs[ADDR_CONFIG];
    assign reg_coarseovf   = wregs[ADDR_COARSEOVF];
    assign reg_clkctrovf   = wregs[ADDR_CLKCTROVF];
    assign reg_clkstopmask = wregs[ADDR_CLKSTOPMASK];
    assign reg_interrupts  = wregs[ADDR_INTERRUPTS];

endmodule
